// File: rtl/hdmi_packet_pkg.sv
// rtl/hdmi_packet_pkg.sv - packet type codes, FSM states and the slot priority function
// Shared by the scheduler; the SPD entry only matters when HDMI_SPD_INFOFRAME_EN is defined.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL         = 8'h00;
    localparam logic [7:0] PKT_ACR          = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE = 8'h02;
    localparam logic [7:0] PKT_AVI_IF       = 8'h82;
    localparam logic [7:0] PKT_SPD_IF       = 8'h83;
    localparam logic [7:0] PKT_AUDIO_IF     = 8'h84;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef struct packed {
        logic aud;
        logic acr;
        logic avi;
        logic aif;
        logic spd;
    } pend_t;

    // Fixed priority: audio never starves behind the once-per-frame infoframes.
    function automatic logic [7:0] arbitrate(input pend_t p);
        if (p.aud)      return PKT_AUDIO_SAMPLE;
        else if (p.acr) return PKT_ACR;
        else if (p.avi) return PKT_AVI_IF;
        else if (p.aif) return PKT_AUDIO_IF;
        else if (p.spd) return PKT_SPD_IF;
        else            return PKT_NULL;
    endfunction

endpackage

// File: rtl/hdmi_acr_timer.sv
// rtl/hdmi_acr_timer.sv - free-running 0..ACR_PERIOD_CLKS-1 counter with a wrap pulse
// o_wrap is high for the single cycle the counter sits at its terminal value.
module hdmi_acr_timer #(
    parameter int ACR_PERIOD_CLKS = 27000
) (
    input  logic clk_pixel,
    input  logic reset_n,
    output logic o_wrap
);

    localparam int W = (ACR_PERIOD_CLKS > 1) ? $clog2(ACR_PERIOD_CLKS) : 1;

    logic [W-1:0] r_count;
    logic         w_at_end;

    assign w_at_end = (r_count == W'(ACR_PERIOD_CLKS - 1));
    assign o_wrap   = w_at_end;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_at_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// rtl/hdmi_packet_scheduler.sv - chooses the packet type for each HDMI data-island slot
// Optional: HDMI_SPD_INFOFRAME_EN adds a once-per-frame SPD infoframe after the audio infoframe.
module hdmi_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int ACR_PERIOD_CLKS   = 27000,
    parameter int AUDIO_PENDING_MAX = 15
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       audio_sample_strobe,
    input  logic       packet_enable,
    output logic [7:0] packet_type,
    output logic       audio_sample_ack,
    output logic       audio_overflow
);

    localparam int CW = $clog2(AUDIO_PENDING_MAX + 1);

    logic [0:0]    r_state;
    logic [7:0]    r_packet_type;
    logic [CW-1:0] r_aud_cnt;
    logic          r_acr_pend;
    logic          r_avi_pend;
    logic          r_aif_pend;
    logic          r_overflow;
    logic          w_spd_pend;
    logic          w_acr_wrap;
    logic          w_commit;
    logic          w_commit_aud;
    logic          w_commit_acr;
    logic          w_commit_avi;
    logic          w_commit_aif;
    pend_t         w_pend;

    hdmi_acr_timer #(
        .ACR_PERIOD_CLKS(ACR_PERIOD_CLKS)
    ) u_acr_timer (
        .clk_pixel(clk_pixel),
        .reset_n  (reset_n),
        .o_wrap   (w_acr_wrap)
    );

    // Only the type latched for the slot is ever committed; null commits nothing.
    assign w_commit     = (r_state == ST_HOLD) && packet_enable;
    assign w_commit_aud = w_commit && (r_packet_type == PKT_AUDIO_SAMPLE);
    assign w_commit_acr = w_commit && (r_packet_type == PKT_ACR);
    assign w_commit_avi = w_commit && (r_packet_type == PKT_AVI_IF);
    assign w_commit_aif = w_commit && (r_packet_type == PKT_AUDIO_IF);

    assign packet_type      = r_packet_type;
    assign audio_sample_ack = w_commit_aud;
    assign audio_overflow   = r_overflow;

`ifdef HDMI_SPD_INFOFRAME_EN
    logic r_spd_pend;
    logic w_commit_spd;

    assign w_commit_spd = w_commit && (r_packet_type == PKT_SPD_IF);
    assign w_spd_pend   = r_spd_pend;

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_spd_pend <= 1'b0;
        end else begin
            r_spd_pend <= frame_start | (r_spd_pend & ~w_commit_spd);
        end
    end
`else
    assign w_spd_pend = 1'b0;
`endif

    assign w_pend = '{aud: (r_aud_cnt != '0), acr: r_acr_pend, avi: r_avi_pend,
                      aif: r_aif_pend, spd: w_spd_pend};

    // Set terms are ORed in last so a new request wins over a same-cycle commit.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_acr_pend <= 1'b0;
            r_avi_pend <= 1'b0;
            r_aif_pend <= 1'b0;
        end else begin
            r_acr_pend <= w_acr_wrap  | (r_acr_pend & ~w_commit_acr);
            r_avi_pend <= frame_start | (r_avi_pend & ~w_commit_avi);
            r_aif_pend <= frame_start | (r_aif_pend & ~w_commit_aif);
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_aud_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            case ({audio_sample_strobe, w_commit_aud})
                2'b10: begin
                    if (r_aud_cnt == CW'(AUDIO_PENDING_MAX)) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_aud_cnt <= r_aud_cnt + 1'b1;
                    end
                end
                2'b01:   r_aud_cnt <= r_aud_cnt - 1'b1;
                default: r_aud_cnt <= r_aud_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_ARB;
            r_packet_type <= PKT_NULL;
        end else begin
            case (r_state)
                ST_ARB: begin
                    r_packet_type <= arbitrate(w_pend);
                    r_state       <= ST_HOLD;
                end
                default: begin
                    if (packet_enable) begin
                        r_packet_type <= PKT_NULL;
                        r_state       <= ST_ARB;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb/tb_hdmi_packet_scheduler.sv - directed table-driven bench for hdmi_packet_scheduler
// Define HDMI_SPD_INFOFRAME_EN for both bench and RTL to exercise the SPD slot.
module tb_hdmi_packet_scheduler;

    logic       clk_pixel;
    logic       reset_n;
    logic       frame_start;
    logic       audio_sample_strobe;
    logic       packet_enable;
    logic [7:0] packet_type;
    logic       audio_sample_ack;
    logic       audio_overflow;

    int n_checks;
    int n_pass;

`ifdef HDMI_SPD_INFOFRAME_EN
    localparam logic [7:0] SPD_EXP = 8'h83;
`else
    localparam logic [7:0] SPD_EXP = 8'h00;
`endif

    typedef struct {
        string      name;
        bit         do_reset;
        int         idle;
        int         strobes;
        bit         frame;
        bit         en;
        bit         en_strobe;
        bit         en_frame;
        logic [7:0] exp_type;
        logic       exp_ack;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    hdmi_packet_scheduler #(
        .ACR_PERIOD_CLKS  (100),
        .AUDIO_PENDING_MAX(15)
    ) dut (
        .clk_pixel          (clk_pixel),
        .reset_n            (reset_n),
        .frame_start        (frame_start),
        .audio_sample_strobe(audio_sample_strobe),
        .packet_enable      (packet_enable),
        .packet_type        (packet_type),
        .audio_sample_ack   (audio_sample_ack),
        .audio_overflow     (audio_overflow)
    );

    initial clk_pixel = 1'b0;
    always #5 clk_pixel = ~clk_pixel;

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input bit rst, input int idle, input int strobes,
                                input bit frame, input bit en, input bit en_strobe, input bit en_frame,
                                input logic [7:0] exp_type, input logic exp_ack, input logic exp_ovf);
        vec_t v;
        v.name = name; v.do_reset = rst; v.idle = idle; v.strobes = strobes; v.frame = frame;
        v.en = en; v.en_strobe = en_strobe; v.en_frame = en_frame;
        v.exp_type = exp_type; v.exp_ack = exp_ack; v.exp_ovf = exp_ovf;
        return v;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        logic got_ack;
        if (v.do_reset) do_reset();
        repeat (v.idle) tick();
        for (int k = 0; k < v.strobes; k++) begin
            audio_sample_strobe = 1'b1;
            tick();
            audio_sample_strobe = 1'b0;
        end
        if (v.frame) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
        got_ack = 1'b0;
        if (v.en) begin
            packet_enable       = 1'b1;
            audio_sample_strobe = v.en_strobe;
            frame_start         = v.en_frame;
            #1 got_ack = audio_sample_ack;
            tick();
            packet_enable       = 1'b0;
            audio_sample_strobe = 1'b0;
            frame_start         = 1'b0;
            tick();
        end
        check({v.name, "_type"}, packet_type, v.exp_type);
        check({v.name, "_ack"}, {7'd0, got_ack}, {7'd0, v.exp_ack});
        check({v.name, "_ovf"}, {7'd0, audio_overflow}, {7'd0, v.exp_ovf});
    endtask

    initial begin
        n_checks            = 0;
        n_pass              = 0;
        reset_n             = 1'b0;
        frame_start         = 1'b0;
        audio_sample_strobe = 1'b0;
        packet_enable       = 1'b0;

        // infoframe sequence after one frame_start
        vecs.push_back(mk("t2_avi",  1, 0, 0, 1, 1, 0, 0, 8'h82, 0, 0));
        vecs.push_back(mk("t2_aif",  0, 0, 0, 0, 1, 0, 0, 8'h84, 0, 0));
        vecs.push_back(mk("t2_spd",  0, 0, 0, 0, 1, 0, 0, SPD_EXP, 0, 0));
        vecs.push_back(mk("t2_null", 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0));
        // five audio samples drain with five acks
        vecs.push_back(mk("t3_first", 1, 0, 5, 0, 1, 0, 0, 8'h02, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(mk("t3_aud", 0, 0, 0, 0, 1, 0, 0, 8'h02, 1, 0));
        vecs.push_back(mk("t3_last", 0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0));
        vecs.push_back(mk("t3_idle", 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0));
        // ACR alone, then ACR behind audio
        vecs.push_back(mk("t4_acr",       1, 105, 0, 0, 1, 0, 0, 8'h01, 0, 0));
        vecs.push_back(mk("t4_acr_done",  0, 0,   0, 0, 1, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk("t4_aud_first", 1, 100, 1, 0, 1, 0, 0, 8'h02, 0, 0));
        vecs.push_back(mk("t4_acr_next",  0, 0,   0, 0, 1, 0, 0, 8'h01, 1, 0));
        vecs.push_back(mk("t4_done",      0, 0,   0, 0, 1, 0, 0, 8'h00, 0, 0));
        // saturation at 15 and sticky overflow
        vecs.push_back(mk("t5_15",    1, 0, 15, 0, 0, 0, 0, 8'h00, 0, 0));
        vecs.push_back(mk("t5_16",    0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 1));
        vecs.push_back(mk("t5_first", 0, 0, 0,  0, 1, 0, 0, 8'h02, 0, 1));
        for (int k = 0; k < 14; k++) vecs.push_back(mk("t5_aud", 0, 0, 0, 0, 1, 0, 0, 8'h02, 1, 1));
        vecs.push_back(mk("t5_last",  0, 0, 0,  0, 1, 0, 0, 8'h00, 1, 1));
        // strobe coincident with audio commit
        vecs.push_back(mk("t6_first", 1, 0, 1, 0, 1, 0, 0, 8'h02, 0, 0));
        vecs.push_back(mk("t6_same",  0, 0, 0, 0, 1, 1, 0, 8'h02, 1, 0));
        vecs.push_back(mk("t6_last",  0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0));
        // frame_start coincident with AVI commit: set wins
        vecs.push_back(mk("sw_avi",  1, 0, 0, 1, 1, 0, 0, 8'h82, 0, 0));
        vecs.push_back(mk("sw_same", 0, 0, 0, 0, 1, 0, 1, 8'h82, 0, 0));
        vecs.push_back(mk("sw_aif",  0, 0, 0, 0, 1, 0, 0, 8'h84, 0, 0));
        vecs.push_back(mk("sw_spd",  0, 0, 0, 0, 1, 0, 0, SPD_EXP, 0, 0));
        vecs.push_back(mk("sw_null", 0, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0));

        do_reset();
        check("reset_type", packet_type, 8'h00);
        check("reset_ovf", {7'd0, audio_overflow}, 8'h00);

        foreach (vecs[i]) apply(vecs[i]);

        // asynchronous reset while holding an audio slot with samples and overflow pending
        apply(mk("t1_hold", 1, 0, 16, 0, 1, 0, 0, 8'h02, 0, 1));
        reset_n = 1'b0;
        #1;
        check("t1_async_type", packet_type, 8'h00);
        check("t1_async_ovf", {7'd0, audio_overflow}, 8'h00);
        tick();
        reset_n = 1'b1;
        apply(mk("t1_after", 0, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0));
        apply(mk("t1_frame", 0, 0, 0, 1, 1, 0, 0, 8'h82, 0, 0));

        // packet_enable held into the ST_ARB cycle commits nothing
        apply(mk("arb_pre", 1, 0, 2, 0, 0, 0, 0, 8'h00, 0, 0));
        packet_enable = 1'b1;
        tick();
        #1;
        check("arb_en_ack", {7'd0, audio_sample_ack}, 8'h00);
        tick();
        packet_enable = 1'b0;
        tick();
        check("arb_en_type", packet_type, 8'h02);
        apply(mk("arb_aud1", 0, 0, 0, 0, 1, 0, 0, 8'h02, 1, 0));
        apply(mk("arb_aud2", 0, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
